// File: rtl/keypad_col_decoder.sv
// rtl/keypad_col_decoder.sv - single-key debouncer and encoder for a row-swept 4x4 keypad.
// Define KEY_REPEAT_EN to re-strobe key_valid every REPEAT_FRAMES samples while a key stays held.
module keypad_col_decoder #(
   parameter int unsigned DEBOUNCE_FRAMES = 8,
   parameter int unsigned REPEAT_FRAMES   = 64
) (
   input  logic       clk_1,
   input  logic       rst_n,
   input  logic [3:0] rows,
   input  logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [15:0] LP_DEB = 16'(DEBOUNCE_FRAMES);
`ifdef KEY_REPEAT_EN
   localparam logic [15:0] LP_REP = 16'(REPEAT_FRAMES);
`endif

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

   state_t      r_state;
   logic [3:0]  r_cols_s1;
   logic [3:0]  r_cols_s2;
   logic [3:0]  r_rows_d1;
   logic [3:0]  r_rows_d2;
   logic [3:0]  r_cand;
   logic [15:0] r_cnt;
   logic [3:0]  r_key_code;
   logic        r_key_valid;
   logic        r_key_held;
`ifdef KEY_REPEAT_EN
   logic [15:0] r_rpt;
   logic [15:0] w_rpt_next;
`endif

   logic        w_row_ok;
   logic        w_col_ok;
   logic [1:0]  w_row_idx;
   logic [1:0]  w_col_idx;
   logic [3:0]  w_sample_code;
   logic [3:0]  w_cand_col_oh;
   logic        w_cand_row;
   logic        w_cand_bit;
   logic [15:0] w_cnt_next;

   function automatic logic [1:0] f_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      if (v[2]) idx = 2'd1;
      if (v[1]) idx = 2'd2;
      if (v[0]) idx = 2'd3;
      return idx;
   endfunction

   // rows is delayed to line up with the synchronized columns it produced
   assign w_row_ok      = $onehot(r_rows_d2);
   assign w_col_ok      = $onehot(r_cols_s2);
   assign w_row_idx     = f_idx(r_rows_d2);
   assign w_col_idx     = f_idx(r_cols_s2);
   assign w_sample_code = {w_row_idx, w_col_idx};
   assign w_cand_col_oh = 4'b1000 >> r_cand[1:0];
   assign w_cand_row    = w_row_ok && (w_row_idx == r_cand[3:2]);
   assign w_cand_bit    = |(r_cols_s2 & w_cand_col_oh);
   assign w_cnt_next    = r_cnt + 16'd1;
`ifdef KEY_REPEAT_EN
   assign w_rpt_next    = r_rpt + 16'd1;
`endif

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cols_s1   <= 4'd0;
         r_cols_s2   <= 4'd0;
         r_rows_d1   <= 4'd0;
         r_rows_d2   <= 4'd0;
         r_cand      <= 4'd0;
         r_cnt       <= 16'd0;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
         r_rpt       <= 16'd0;
`endif
      end else begin
         r_cols_s1   <= cols;
         r_cols_s2   <= r_cols_s1;
         r_rows_d1   <= rows;
         r_rows_d2   <= r_rows_d1;
         r_key_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_row_ok && w_col_ok) begin
                  r_cand <= w_sample_code;
                  r_cnt  <= 16'd1;
                  if (LP_DEB <= 16'd1) begin
                     r_state     <= S_PRESSED;
                     r_key_code  <= w_sample_code;
                     r_key_valid <= 1'b1;
                     r_key_held  <= 1'b1;
`ifdef KEY_REPEAT_EN
                     r_rpt       <= 16'd0;
`endif
                  end else begin
                     r_state <= S_DEBOUNCE;
                  end
               end
            end
            S_DEBOUNCE: begin
               if (w_cand_row) begin
                  if (r_cols_s2 == w_cand_col_oh) begin
                     if (w_cnt_next >= LP_DEB) begin
                        r_state     <= S_PRESSED;
                        r_key_code  <= r_cand;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
`ifdef KEY_REPEAT_EN
                        r_rpt       <= 16'd0;
`endif
                     end else begin
                        r_cnt <= w_cnt_next;
                     end
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_PRESSED: begin
               if (w_cand_row) begin
                  if (!w_cand_bit) begin
                     r_cnt <= 16'd1;
`ifdef KEY_REPEAT_EN
                     r_rpt <= 16'd0;
`endif
                     if (LP_DEB <= 16'd1) begin
                        r_state    <= S_IDLE;
                        r_key_held <= 1'b0;
                     end else begin
                        r_state <= S_RELEASE;
                     end
                  end
`ifdef KEY_REPEAT_EN
                  // a repeat due right after a strobe waits for the next sample
                  else if (w_rpt_next >= LP_REP) begin
                     if (!r_key_valid) begin
                        r_key_valid <= 1'b1;
                        r_rpt       <= 16'd0;
                     end
                  end else begin
                     r_rpt <= w_rpt_next;
                  end
`endif
               end
            end
            S_RELEASE: begin
               if (w_cand_row) begin
                  if (w_cand_bit) begin
                     r_state <= S_PRESSED;
`ifdef KEY_REPEAT_EN
                     r_rpt   <= 16'd0;
`endif
                  end else if (w_cnt_next >= LP_DEB) begin
                     r_state    <= S_IDLE;
                     r_key_held <= 1'b0;
                  end else begin
                     r_cnt <= w_cnt_next;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_col_decoder.sv
// tb/tb_keypad_col_decoder.sv - scoreboard bench: sweeper + keypad matrix model against a sample-level key reference.
module tb_keypad_col_decoder;

   localparam int DEB = 4;
   localparam int REP = 8;

   logic       clk_1 = 1'b0;
   logic       rst_n;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   always #5 clk_1 = ~clk_1;

   keypad_col_decoder #(.DEBOUNCE_FRAMES(DEB), .REPEAT_FRAMES(REP)) u_dut (
      .clk_1    (clk_1),
      .rst_n    (rst_n),
      .rows     (rows),
      .cols     (cols),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int nvalid  = 0;
   int edge_no = 0;

   logic [15:0] keys;
   int          sweep;
   bit          gap_en;

   int         exp_edge_q[$];
   logic [3:0] exp_code_q[$];

   int         m_cand;
   int         m_run;
   int         m_clr;
   int         m_rpt;
   bit         m_held;
   logic [3:0] m_last_code;
   logic [3:0] pr[2];
   logic [3:0] pc[2];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_cand = -1; m_run = 0; m_clr = 0; m_rpt = 0;
      m_held = 1'b0; m_last_code = 4'd0;
      pr[0] = 4'd0; pr[1] = 4'd0; pc[0] = 4'd0; pc[1] = 4'd0;
      exp_edge_q.delete(); exp_code_q.delete();
   endtask

   task automatic emit(input logic [3:0] code);
      exp_edge_q.push_back(edge_no);
      exp_code_q.push_back(code);
   endtask

   task automatic accept();
      m_held = 1'b1; m_clr = 0; m_rpt = 0;
      m_last_code = 4'(m_cand);
      emit(m_last_code);
   endtask

   // evaluates the sample the DUT sees at this edge: pins captured two edges earlier
   task automatic model_step();
      logic [3:0] er, ec;
      int row, col;
      bit down;
      edge_no++;
      if (!rst_n) begin
         model_clear();
         return;
      end
      er = pr[1]; ec = pc[1];
      pr[1] = pr[0]; pc[1] = pc[0];
      pr[0] = rows;  pc[0] = cols;
      if ($countones(er) != 1) return;
      row = 0; col = 0;
      for (int i = 0; i < 4; i++) begin
         if (er[3-i]) row = i;
         if (ec[3-i]) col = i;
      end
      if (m_cand < 0) begin
         if ($countones(ec) == 1) begin
            m_cand = row * 4 + col;
            m_run = 1;
            if (m_run >= DEB) accept();
         end
      end else if (!m_held) begin
         if (row == m_cand / 4) begin
            if ($countones(ec) == 1 && col == m_cand % 4) begin
               m_run++;
               if (m_run >= DEB) accept();
            end else begin
               m_cand = -1;
            end
         end
      end else if (row == m_cand / 4) begin
         down = ec[3 - (m_cand % 4)];
         if (down) begin
            if (m_clr > 0) begin
               m_clr = 0; m_rpt = 0;
            end else begin
`ifdef KEY_REPEAT_EN
               m_rpt++;
               if (m_rpt == REP) begin
                  m_rpt = 0;
                  emit(m_last_code);
               end
`endif
            end
         end else begin
            m_clr++; m_rpt = 0;
            if (m_clr >= DEB) begin
               m_held = 1'b0; m_clr = 0; m_cand = -1;
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk_1);
      model_step();
      #2;
      if (gap_en && $urandom_range(0, 7) == 0) begin
         rows = 4'd0;
         cols = 4'($urandom);
      end else begin
         rows = 4'b1000 >> sweep;
         cols = {keys[sweep*4], keys[sweep*4+1], keys[sweep*4+2], keys[sweep*4+3]};
         sweep = (sweep + 1) % 4;
      end
   endtask

   task automatic frames(input int n);
      repeat (4 * n) cyc();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      model_clear();
      repeat (n) cyc();
      rst_n = 1'b1;
   endtask

   task automatic monitor();
      int e;
      logic [3:0] c;
      forever begin
         @(negedge clk_1);
         if (key_valid) begin
            nvalid++;
            if (exp_edge_q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               e = exp_edge_q.pop_front();
               c = exp_code_q.pop_front();
               chk("strobe_edge", edge_no, e);
               chk("strobe_code", int'(key_code), int'(c));
            end
         end else if (exp_edge_q.size() > 0 && exp_edge_q[0] <= edge_no) begin
            chk("missed_strobe_at_edge", 0, exp_edge_q[0]);
            void'(exp_edge_q.pop_front());
            void'(exp_code_q.pop_front());
         end
         chk("key_held", int'(key_held), int'(m_held));
         chk("key_code", int'(key_code), int'(m_last_code));
      end
   endtask

   initial begin
      int v0, k, n;
      rst_n = 1'b0; rows = 4'd0; cols = 4'd0; keys = 16'd0;
      sweep = 0; gap_en = 1'b0;
      model_clear();
      fork monitor(); join_none
      #1;
      chk("rst_code", int'(key_code), 0);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_held", int'(key_held), 0);
      repeat (3) cyc();
      rst_n = 1'b1;
      frames(2);

      // 1: clean press row0/col2
      v0 = nvalid; keys[2] = 1'b1; frames(10);
      chk("t1_strobes", nvalid - v0, 1);
      chk("t1_code", int'(key_code), 2);
      chk("t1_held", int'(key_held), 1);
      keys = 16'd0; frames(5);
      chk("t1_released", int'(key_held), 0);

      // 2: bouncing row1/col1
      v0 = nvalid;
      for (int i = 0; i < 6; i++) begin
         keys[5] = (i % 2 == 0);
         frames(1);
      end
      keys = 16'd0; frames(2);
      chk("t2_strobes", nvalid - v0, 0);
      chk("t2_held", int'(key_held), 0);

      // 3: two columns in row2
      v0 = nvalid; keys[8] = 1'b1; keys[9] = 1'b1; frames(10);
      keys = 16'd0; frames(2);
      chk("t3_strobes", nvalid - v0, 0);

      // 4: hold F, then add row1/col0
      v0 = nvalid; keys[15] = 1'b1; frames(6);
      keys[4] = 1'b1; frames(6);
      chk("t4_strobes", nvalid - v0, 1);
      chk("t4_code", int'(key_code), 15);
      keys = 16'd0; frames(6);

      // 5: reset during debounce of row2/col1
      keys[9] = 1'b1; frames(2);
      rst_n = 1'b0; model_clear(); #1;
      chk("t5_rst_code", int'(key_code), 0);
      chk("t5_rst_held", int'(key_held), 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      v0 = nvalid; frames(8);
      chk("t5_strobes", nvalid - v0, 1);
      chk("t5_code", int'(key_code), 9);
      keys = 16'd0; frames(6);

      // 6: long hold of row0/col0
      v0 = nvalid; keys[0] = 1'b1; frames(30);
      keys = 16'd0; frames(2);
`ifdef KEY_REPEAT_EN
      chk("t6_strobes", nvalid - v0, 4);
`else
      chk("t6_strobes", nvalid - v0, 1);
`endif
      chk("t6_code", int'(key_code), 0);
      frames(6);

      // random presses with bounce, ghost keys, sweep gaps and resets
      gap_en = 1'b1;
      for (int it = 0; it < 40; it++) begin
         keys = 16'd0;
         k = $urandom_range(0, 15);
         keys[k] = 1'b1;
         n = $urandom_range(1, 12);
         for (int f = 0; f < n; f++) begin
            frames(1);
            if ($urandom_range(0, 4) == 0) keys[k] = ~keys[k];
            if ($urandom_range(0, 6) == 0) keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 22) == 0) do_reset(2);
         end
         keys = 16'd0;
         frames($urandom_range(0, 8));
      end
      gap_en = 1'b0;
      frames(10);
      chk("queue_drained", exp_edge_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
